lcd_avalon_arbiter: RTL and testbench



---
 rtl/lcd_avalon_arbiter_if.sv | 21 ++
 rtl/lcd_avalon_arbiter.sv | 115 +++++++++++
 tb/tb_lcd_avalon_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_avalon_arbiter_if.sv
// Avalon-MM channel used on each side of the character-LCD arbiter (1-bit address, 8-bit data).
interface lcd_avalon_arbiter_if;
    logic       address;
    logic       chipselect;
    logic       read;
    logic       write;
    logic [7:0] writedata;
    logic       lock;
    logic [7:0] readdata;
    logic       waitrequest;

    modport master (
        output address, chipselect, read, write, writedata, lock,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, writedata, lock,
        output readdata, waitrequest
    );
endinterface

// File: rtl/lcd_avalon_arbiter.sv
// Round-robin, transaction-level arbiter sharing one LCD controller slave between two Avalon masters.
// Optional stalled-slave watchdog enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_avalon_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    lcd_avalon_arbiter_if.slave  m0,
    lcd_avalon_arbiter_if.slave  m1,
    lcd_avalon_arbiter_if.master s,
    output logic [1:0]           grant,
    output logic                 timeout_err
);
    // One-hot owner encoding doubles as the registered grant output.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    state_e state_q;
    logic   last_q;
    logic   m0_req, m1_req;
    logic   own0, own1;
    logic   abort;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    assign m0_req = m0.chipselect & (m0.read | m0.write);
    assign m1_req = m1.chipselect & (m1.read | m1.write);
    assign own0   = (state_q == OWN0);
    assign own1   = (state_q == OWN1);
    assign grant  = state_q;

    // Strobes derive from the asynchronously reset state, so reset drops them immediately.
    assign s.address    = own1 ? m1.address   : m0.address;
    assign s.writedata  = own1 ? m1.writedata : m0.writedata;
    assign s.chipselect = (own0 & m0.chipselect) | (own1 & m1.chipselect);
    assign s.read       = (own0 & m0.read)       | (own1 & m1.read);
    assign s.write      = (own0 & m0.write)      | (own1 & m1.write);
    assign s.lock       = 1'b0;

    assign m0.waitrequest = own0 ? (s.waitrequest & ~abort) : 1'b1;
    assign m1.waitrequest = own1 ? (s.waitrequest & ~abort) : 1'b1;
    assign m0.readdata    = (own0 & abort) ? 8'h00 : s.readdata;
    assign m1.readdata    = (own1 & abort) ? 8'h00 : s.readdata;

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q;
    logic            stall;

    assign stall       = ((own0 & m0_req) | (own1 & m1_req)) & s.waitrequest;
    assign abort       = stall & (cnt_q == CntLast);
    assign timeout_err = abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (stall && !abort) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // NOTE: state flops use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_req && (!m1_req || last_q)) begin
                        state_q <= OWN0;
                    end else if (m1_req) begin
                        state_q <= OWN1;
                    end
                end
                OWN0: begin
                    if (abort) begin
                        state_q <= IDLE;
                        last_q  <= 1'b0;
                    end else if (m0_req && !s.waitrequest) begin
                        last_q <= 1'b0;
                        if (!m0.lock) state_q <= IDLE;
                    end else if (!m0_req && !m0.lock) begin
                        state_q <= IDLE;
                    end
                end
                OWN1: begin
                    if (abort) begin
                        state_q <= IDLE;
                        last_q  <= 1'b1;
                    end else if (m1_req && !s.waitrequest) begin
                        last_q <= 1'b1;
                        if (!m1.lock) state_q <= IDLE;
                    end else if (!m1_req && !m1.lock) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_avalon_arbiter.sv
// Scoreboard bench for lcd_avalon_arbiter: reset, single write, round-robin, lock, read and watchdog.
`timescale 1ns/1ps
module tb_lcd_avalon_arbiter;
    typedef struct packed {
        logic       we;
        logic       addr;
        logic [7:0] data;
    } xfer_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant;
    logic       timeout_err;

    lcd_avalon_arbiter_if m0_if ();
    lcd_avalon_arbiter_if m1_if ();
    lcd_avalon_arbiter_if s_if ();

    int          n_checks = 0;
    int          n_errors = 0;
    xfer_t       sb0[$];
    xfer_t       sb1[$];
    int          done_log[$];
    logic [1:0]  gexp[$];
    int unsigned slave_wait  = 0;
    logic        stuck       = 1'b0;
    logic [7:0]  slave_rdata = 8'h00;
    int unsigned wcnt;
    int unsigned act_cycles = 0;
    int unsigned to_cnt     = 0;
    xfer_t       mon_e;
    int          mon_own;
    int          mon_n;

    always #5 clk = ~clk;

    lcd_avalon_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .m0          (m0_if),
        .m1          (m1_if),
        .s           (s_if),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    // Slave model: stalls each transfer for slave_wait cycles, or forever while stuck.
    assign s_if.waitrequest = stuck | (s_if.chipselect & (wcnt < slave_wait));
    assign s_if.readdata    = slave_rdata;

    always @(posedge clk or posedge reset) begin
        if (reset)                                     wcnt <= 0;
        else if (s_if.chipselect && s_if.waitrequest) wcnt <= wcnt + 1;
        else                                           wcnt <= 0;
    end

    always @(negedge clk) begin
        if (s_if.chipselect && s_if.write && s_if.address && s_if.writedata == 8'h41)
            act_cycles <= act_cycles + 1;
        if (timeout_err) to_cnt <= to_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave-side scoreboard: every completed transfer must match what its owner issued.
    always @(negedge clk) begin
        if (!reset && s_if.chipselect && !s_if.waitrequest) begin
            check("sb_owner", 32'(grant == 2'b01 || grant == 2'b10), 1);
            mon_own = (grant == 2'b10) ? 1 : 0;
            mon_n   = (mon_own == 1) ? sb1.size() : sb0.size();
            check("sb_pending", 32'(mon_n > 0), 1);
            if (mon_n > 0) begin
                if (mon_own == 1) mon_e = sb1.pop_front();
                else              mon_e = sb0.pop_front();
                check("sb_addr", s_if.address, mon_e.addr);
                check("sb_kind", s_if.write, mon_e.we);
                check("sb_read", s_if.read, !mon_e.we);
                if (mon_e.we) check("sb_wdata", s_if.writedata, mon_e.data);
            end
            done_log.push_back(mon_own);
        end
    end

    task automatic drive(input int n, input bit cs, input bit rd, input bit wr,
                         input bit a, input bit [7:0] d, input bit lk);
        if (n == 0) begin
            m0_if.chipselect = cs; m0_if.read = rd; m0_if.write = wr;
            m0_if.address = a; m0_if.writedata = d; m0_if.lock = lk;
        end else begin
            m1_if.chipselect = cs; m1_if.read = rd; m1_if.write = wr;
            m1_if.address = a; m1_if.writedata = d; m1_if.lock = lk;
        end
    endtask

    task automatic m_idle(input int n);
        drive(n, 0, 0, 0, 0, 8'h00, 0);
    endtask

    function automatic logic wait_of(input int n);
        return (n == 0) ? m0_if.waitrequest : m1_if.waitrequest;
    endfunction

    function automatic logic [7:0] rd_of(input int n);
        return (n == 0) ? m0_if.readdata : m1_if.readdata;
    endfunction

    // One Avalon transfer; returns at posedge+1 with strobes still held, cyc = cycles until waitrequest low.
    task automatic m_xfer(input int n, input bit we, input bit a, input bit [7:0] d, input bit lk,
                          input bit [7:0] exp_rd, input bit track, output int cyc);
        xfer_t e;
        drive(n, 1, !we, we, a, d, lk);
        if (track) begin
            e.we = we; e.addr = a; e.data = d;
            if (n == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (wait_of(n) && cyc < 2000);
        check($sformatf("m%0d_done", n), wait_of(n), 0);
        if (!we) check($sformatf("m%0d_rdata", n), rd_of(n), exp_rd);
        @(posedge clk);
        #1;
    endtask

    task automatic grant_seq(input string tag);
        logic [1:0] e;
        while (gexp.size() > 0) begin
            @(negedge clk);
            e = gexp.pop_front();
            check(tag, grant, e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c, bad;
        int unsigned a0, t0;

        reset = 1'b1;
        m_idle(0);
        m_idle(1);
        #3;
        check("rst_grant", grant, 2'b00);
        check("rst_cs", s_if.chipselect, 0);
        check("rst_wr", s_if.write, 0);
        check("rst_wait0", m0_if.waitrequest, 1);
        check("rst_wait1", m1_if.waitrequest, 1);
        check("rst_to", timeout_err, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Reset asserted in the middle of a stalled transfer.
        stuck = 1'b1;
        drive(0, 1, 0, 1, 1, 8'h33, 0);
        @(negedge clk); @(negedge clk);
        check("pre_rst_grant", grant, 2'b01);
        check("pre_rst_cs", s_if.chipselect, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_cs", s_if.chipselect, 0);
        check("mid_rst_wait0", m0_if.waitrequest, 1);
        check("mid_rst_wait1", m1_if.waitrequest, 1);
        check("mid_rst_grant", grant, 2'b00);
        m_idle(0);
        stuck = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Round-robin, both masters continuously requesting, zero-wait slave; first tie to m0.
        done_log.delete();
        gexp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00,
                 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        fork
            grant_seq("rr_grant");
            begin
                for (int i = 0; i < 3; i++) begin
                    m_xfer(0, 1, 0, 8'h10 + 8'(i), 0, 8'h00, 1, c0);
                    check("rr_m0_lat", c0, (i == 0) ? 2 : 4);
                end
                m_idle(0);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    m_xfer(1, 1, 1, 8'h20 + 8'(i), 0, 8'h00, 1, c1);
                    check("rr_m1_lat", c1, 4);
                end
                m_idle(1);
            end
        join
        @(posedge clk); #1;
        check("rr_count", done_log.size(), 6);
        for (int i = 0; i < 6 && i < done_log.size(); i++) check("rr_order", done_log[i], i % 2);

        // Single write with three slave wait cycles.
        slave_wait = 3;
        a0 = act_cycles;
        m_xfer(0, 1, 1, 8'h41, 0, 8'h00, 1, c);
        check("wr_lat", c, 5);
        check("wr_active", act_cycles - a0, 4);
        m_idle(0);
        @(negedge clk);
        check("wr_release", grant, 2'b00);
        @(posedge clk); #1;

        // Locked three-write sequence from m1 while m0 waits.
        slave_wait = 0;
        done_log.delete();
        gexp = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00};
        fork
            grant_seq("lk_grant");
            begin
                m_xfer(1, 1, 0, 8'h80, 1, 8'h00, 1, c1);
                check("lk_lat0", c1, 2);
                m_xfer(1, 1, 1, 8'h48, 1, 8'h00, 1, c1);
                check("lk_lat1", c1, 1);
                m_xfer(1, 1, 1, 8'h49, 1, 8'h00, 1, c1);
                check("lk_lat2", c1, 1);
                m_idle(1);
            end
            begin
                @(posedge clk); #1;
                m_xfer(0, 1, 0, 8'h21, 0, 8'h00, 1, c0);
                check("lk_m0_wait", c0, 6);
                m_idle(0);
            end
        join
        @(posedge clk); #1;
        check("lk_count", done_log.size(), 4);
        for (int i = 0; i < 4 && i < done_log.size(); i++) check("lk_order", done_log[i], (i < 3) ? 1 : 0);

        // Read with two wait cycles.
        slave_wait  = 2;
        slave_rdata = 8'h5A;
        m_xfer(1, 0, 0, 8'h00, 0, 8'h5A, 1, c);
        check("rd_lat", c, 4);
        m_idle(1);
        @(posedge clk); #1;

        // Slave that never completes.
        stuck       = 1'b1;
        slave_rdata = 8'hA5;
`ifdef LCD_ARB_TIMEOUT_EN
        t0 = to_cnt;
        m_xfer(0, 0, 1, 8'h00, 0, 8'h00, 0, c);
        check("to_lat", c, 17);
        m_idle(0);
        @(negedge clk);
        check("to_idle", grant, 2'b00);
        check("to_pulse", to_cnt - t0, 1);
`else
        t0  = to_cnt;
        bad = 0;
        drive(0, 1, 1, 0, 1, 8'h00, 0);
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (!m0_if.waitrequest || timeout_err) bad++;
        end
        check("stall_hold", bad, 0);
        check("stall_grant", grant, 2'b01);
        check("stall_no_to", to_cnt - t0, 0);
        m_idle(0);
`endif
        stuck = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        check("sb0_left", sb0.size(), 0);
        check("sb1_left", sb1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
